// File: rtl/rns_pkg.sv
// rns_pkg: shared FSM states, moduli (2^N, 2^N-1, 2^N+1) and modular add/sub/fold helpers
// for the mixed-radix RNS-to-binary converter.
package rns_pkg;
  typedef enum logic [2:0] {IDLE, V2, V3, ACC, DONE} state_t;
  function automatic int m1_of(input int n);
    return 1 << n;
  endfunction
  function automatic int m2_of(input int n);
    return (1 << n) - 1;
  endfunction
  function automatic int m3_of(input int n);
    return (1 << n) + 1;
  endfunction
  localparam int N_DEF = 4;
  localparam int M1_DEF = m1_of(N_DEF);
  localparam int M2_DEF = m2_of(N_DEF);
  localparam int M3_DEF = m3_of(N_DEF);
  localparam int MOD_M_DEF = M1_DEF * M2_DEF * M3_DEF;
  function automatic int mod_add(input int a, input int b, input int m);
    int s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction
  function automatic int mod_sub(input int a, input int b, input int m);
    return (a >= b) ? a - b : a + m - b;
  endfunction
  // 2^n == -1 mod 2^n+1, so the high half folds back as a subtraction
  function automatic int fold_m3(input int y, input int n);
    return mod_sub(y & ((1 << n) - 1), y >> n, m3_of(n));
  endfunction
endpackage

// File: rtl/rns2bin_mrc_if.sv
// rns2bin_mrc_if: residue-in / binary-out handshake bundle for rns2bin_mrc.
interface rns2bin_mrc_if #(parameter int N = 4);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   r1;
  logic [N-1:0]   r2;
  logic [N:0]     r3;
  logic           out_valid;
  logic           out_ready;
  logic [3*N-1:0] x;
  logic           out_err;
  modport master (output in_valid, r1, r2, r3, out_ready,
                  input  in_ready, out_valid, x, out_err);
  modport slave  (input  in_valid, r1, r2, r3, out_ready,
                  output in_ready, out_valid, x, out_err);
endinterface

// File: rtl/rns_modsub.sv
// rns_modsub: (a - b) mod m with m selectable at run time between 2^N-1 and 2^N+1;
// both operands must already be reduced below the selected modulus.
module rns_modsub
  import rns_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       i_m3,
  input  logic [N:0] i_a,
  input  logic [N:0] i_b,
  output logic [N:0] o_d
);
  logic [N+1:0] w_m;
  logic [N+1:0] w_diff;
  assign w_m    = i_m3 ? (N+2)'(m3_of(N)) : (N+2)'(m2_of(N));
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign o_d    = w_diff[N+1] ? (N+1)'(w_diff + w_m) : w_diff[N:0];
endmodule

// File: rtl/rns2bin_mrc.sv
// rns2bin_mrc: RNS {2^N, 2^N-1, 2^N+1} to binary by multiplier-free mixed-radix conversion.
// Define SIGNED_OUT_EN to emit x as two's complement over the symmetric range of M.
module rns2bin_mrc
  import rns_pkg::*;
#(
  parameter int N = 4
) (
  input logic        clk,
  input logic        reset,
  rns2bin_mrc_if.slave bus
);
  localparam int W = 3 * N;
  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_v1;
  logic [N-1:0]   r_r2;
  logic [N:0]     r_r3;
  logic [N-1:0]   r_v2;
  logic [N:0]     r_v3;
  logic [W-1:0]   r_x;
  logic           r_err;
  logic           w_in_ready;
  logic           w_out_valid;
  logic           w_accept;
  logic           w_m3;
  logic [N-1:0]   w_r2c;
  logic [N-1:0]   w_v1c;
  logic [N:0]     w_a;
  logic [N:0]     w_b;
  logic [N:0]     w_d;
  logic [N:0]     w_v3;
  logic [2*N:0]   w_hi;
  logic [W-1:0]   w_xu;
  logic [W-1:0]   w_x;
  logic           w_err;
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_next     = bus.in_valid ? V2 : IDLE;
      end
      V2:   w_next = V3;
      V3:   w_next = ACC;
      ACC:  w_next = DONE;
      DONE: begin
        w_out_valid = 1'b1;
        w_next      = bus.out_ready ? IDLE : DONE;
      end
      default: w_next = IDLE;
    endcase
  end
  assign w_accept = bus.in_valid && w_in_ready;
  // all-ones r2 is the redundant encoding of zero mod 2^N-1
  assign w_r2c = (r_r2 == {N{1'b1}}) ? {N{1'b0}} : r_r2;
  assign w_v1c = (r_v1 == {N{1'b1}}) ? {N{1'b0}} : r_v1;
  // one shared subtractor: r2-v1 mod m2 in V2, v1-(r3+v2) mod m3 in V3
  assign w_m3 = (r_state == V3);
  assign w_a  = w_m3 ? {1'b0, r_v1} : {1'b0, w_r2c};
  assign w_b  = w_m3 ? (N+1)'(mod_add(int'(r_r3), int'(r_v2), m3_of(N))) : {1'b0, w_v1c};
  rns_modsub #(.N(N)) u_modsub (
    .i_m3 (w_m3),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_d  (w_d)
  );
  assign w_v3 = (N+1)'(fold_m3(int'(w_d) << (N - 1), N));
  // v2 + m2*v3 = v2 + (v3<<N) - v3, then X = v1 + (that << N)
  assign w_hi  = {r_v3, {N{1'b0}}} - (2*N+1)'(r_v3) + (2*N+1)'(r_v2);
  assign w_xu  = W'({w_hi, r_v1});
  assign w_err = r_r3 > (N+1)'(m1_of(N));
`ifdef SIGNED_OUT_EN
  localparam logic [W-1:0] MOD_M = W'(m1_of(N) * m2_of(N) * m3_of(N));
  assign w_x = (w_xu >= (MOD_M >> 1)) ? w_xu - MOD_M : w_xu;
`else
  assign w_x = w_xu;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_v1    <= '0;
      r_r2    <= '0;
      r_r3    <= '0;
      r_v2    <= '0;
      r_v3    <= '0;
      r_x     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_v1 <= bus.r1;
        r_r2 <= bus.r2;
        r_r3 <= bus.r3;
      end
      if (r_state == V2) r_v2 <= N'(w_d);
      if (r_state == V3) r_v3 <= w_v3;
      if (r_state == ACC) begin
        r_err <= w_err;
        r_x   <= w_err ? '0 : w_x;
      end
    end
  end
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.x         = r_x;
  assign bus.out_err   = r_err;
endmodule

// File: tb/tb_rns2bin_mrc.sv
// tb_rns2bin_mrc: directed and random residue triples against a brute-force CRT reference (N=4).
module tb_rns2bin_mrc;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  rns2bin_mrc_if #(.N(4)) bus ();
  rns2bin_mrc #(.N(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // reference: search [0, M) for the unique X matching all three residues
  function automatic int ref_x(int a, int b, int c);
    if (c > 16) return 0;
    for (int v = 0; v < 4080; v++)
      if (v % 16 == a && v % 15 == b % 15 && v % 17 == c)
`ifdef SIGNED_OUT_EN
        return (v >= 2040) ? ((v - 4080) & 'hFFF) : v;
`else
        return v;
`endif
    return -1;
  endfunction
  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic convert(int a, int b, int c, int hold);
    int exp_x;
    exp_x = ref_x(a, b, c);
    @(negedge clk);
    check("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.r1 = 4'(a);
    bus.r2 = 4'(b);
    bus.r3 = 5'(c);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_busy", int'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    check("early_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    check("out_valid", int'(bus.out_valid), 1);
    check("x", int'(bus.x), exp_x);
    check("out_err", int'(bus.out_err), int'(c > 16));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.r1 = 4'($urandom);
      bus.r2 = 4'($urandom);
      bus.r3 = 5'($urandom_range(0, 16));
      @(negedge clk);
      check("hold_x", int'(bus.x), exp_x);
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("consumed", int'(bus.out_valid), 0);
    check("no_accept_on_consume", int'(bus.in_ready), 1);
  endtask
  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.r1 = '0;
    bus.r2 = '0;
    bus.r3 = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_x", int'(bus.x), 0);
    check("rst_out_err", int'(bus.out_err), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    convert(8, 10, 14, 0);
    convert(0, 0, 0, 0);
    convert(0, 15, 0, 0);
    convert(15, 14, 16, 0);
    convert(3, 7, 18, 0);
    convert(8, 10, 14, 10);
    // reset while the conversion sits in V3
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.r1 = 4'd8;
    bus.r2 = 4'd10;
    bus.r3 = 5'd14;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_x", int'(bus.x), 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen |= int'(bus.out_valid);
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen |= int'(bus.out_valid);
    end
    check("abort_no_valid", seen, 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    convert(8, 10, 14, 0);
    for (int k = 0; k < 25; k++)
      convert(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 18)), int'($urandom_range(0, 2)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
